// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver.
//   DATA_BITS  : payload bits per 8N1 frame
//   rx_state_e : receiver FSM state encoding (3 bits)
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk   : destination clock
//   reset : asynchronous active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles behind d
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 receiver feeding an 8-bit load register.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   rx        : serial line, idle high, asynchronous to clk
//   data_out  : last good received byte, held between frames
//   load      : one-cycle strobe, data_out newly valid this cycle
//   frame_err : one-cycle strobe, stop bit sampled low and byte discarded
//   busy      : high whenever the FSM is not in IDLE
//
// Handshake: load and frame_err are valid-only strobes with no ready/back-
// pressure. The consumer must take data_out in the single cycle load is high;
// data_out and load change on the same clock edge so they can drive a
// register's data_in/load directly. The two strobes are mutually exclusive.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 load,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [2:0]           bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [DATA_BITS-1:0] data_nxt;
   logic                 load_nxt, ferr_nxt;

   // Line idles high, so presetting the synchroniser to 1 keeps a reset
   // release from looking like a start edge.
   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data_out  <= '0;
         load      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shreg     <= shreg_nxt;
         data_out  <= data_nxt;
         load      <= load_nxt;
         frame_err <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + 1'b1;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      data_nxt    = data_out;
      load_nxt    = 1'b0;
      ferr_nxt    = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // Re-check the line half a bit in: a short low pulse is a glitch.
            if (cnt == CNT_HALF) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  state_nxt   = DATA;
                  bit_idx_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            // Timer is already aligned to mid-bit by the START half period.
            if (cnt == CNT_LAST) begin
               cnt_nxt            = '0;
               shreg_nxt[bit_idx] = rx_s;
               if (bit_idx == IDX_LAST) state_nxt = STOP;
               else                     bit_idx_nxt = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  data_nxt  = shreg;
                  load_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            // Hold off until the line is released so a stuck-low line
            // cannot look like an endless stream of start bits.
            cnt_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
module tb_uart_byte_rx;

   localparam int CPB = 16;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] data_out;
   logic       load;
   logic       frame_err;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   int         load_cnt    = 0;
   int         ferr_cnt    = 0;
   int         overlap_cnt = 0;
   logic [7:0] got_q[$];

   uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data_out  (data_out),
      .load      (load),
      .frame_err (frame_err),
      .busy      (busy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- strobe monitor ----------------
   always @(negedge clk) begin
      if (reset) begin
         if (load) begin
            load_cnt++;
            got_q.push_back(data_out);
         end
         if (frame_err) ferr_cnt++;
         if (load && frame_err) overlap_cnt++;
      end
   end

   // ---------------- drivers (called at a negedge, return at a negedge) ----
   task automatic send_bits(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      send_bits(1'b0);
      for (int i = 0; i < 8; i++) send_bits(b[i]);
      send_bits(stop_bit);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rx = ~rx;
         @(negedge clk);
      end
      vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", data_out); end
      vectors++; if (load !== 1'b0) begin miscompares++; $display("FAIL reset_load got %b want 0", load); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr got %b want 0", frame_err); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      rx = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (100) @(negedge clk);
      vectors++; if (load_cnt !== 0) begin miscompares++; $display("FAIL idle_loads got %0d want 0", load_cnt); end
      vectors++; if (ferr_cnt !== 0) begin miscompares++; $display("FAIL idle_ferrs got %0d want 0", ferr_cnt); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_good_byte();
      int lb     = load_cnt;
      int fb     = ferr_cnt;
      int cycles = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            @(posedge clk);
            while (load !== 1'b1 && cycles < 200) begin
               @(posedge clk);
               #1;
               cycles++;
            end
         end
      join
      vectors++; if (cycles !== 154) begin miscompares++; $display("FAIL good_latency got %0d want 154", cycles); end
      vectors++; if (load_cnt !== lb + 1) begin miscompares++; $display("FAIL good_loads got %0d want %0d", load_cnt - lb, 1); end
      vectors++; if (data_out !== 8'hA5) begin miscompares++; $display("FAIL good_data got %h want a5", data_out); end
      vectors++; if (ferr_cnt !== fb) begin miscompares++; $display("FAIL good_ferr got %0d want 0", ferr_cnt - fb); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] g0, g1;
      got_q.delete();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      repeat (4) @(negedge clk);
      g0 = (got_q.size() > 0) ? got_q[0] : 8'hxx;
      g1 = (got_q.size() > 1) ? got_q[1] : 8'hxx;
      vectors++; if (got_q.size() !== 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", got_q.size()); end
      vectors++; if (g0 !== 8'h00) begin miscompares++; $display("FAIL b2b_first got %h want 00", g0); end
      vectors++; if (g1 !== 8'hFF) begin miscompares++; $display("FAIL b2b_second got %h want ff", g1); end
   endtask

   task automatic test_glitch();
      int lb = load_cnt;
      int fb = ferr_cnt;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_rise got %b want 1", busy); end
      rx = 1'b1;
      repeat (12) @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_drop got %b want 0", busy); end
      vectors++; if (load_cnt !== lb) begin miscompares++; $display("FAIL glitch_load got %0d want 0", load_cnt - lb); end
      vectors++; if (ferr_cnt !== fb) begin miscompares++; $display("FAIL glitch_ferr got %0d want 0", ferr_cnt - fb); end
   endtask

   task automatic test_frame_error();
      logic [7:0] b  = 8'h3C;
      int         lb = load_cnt;
      int         fb = ferr_cnt;
      send_bits(1'b0);
      for (int i = 0; i < 8; i++) send_bits(b[i]);
      rx = 1'b0;
      repeat (30) @(negedge clk);
      vectors++; if (ferr_cnt !== fb + 1) begin miscompares++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - fb); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ferr_busy_held got %b want 1", busy); end
      repeat (10) @(negedge clk);
      rx = 1'b1;
      repeat (12) @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_busy_drop got %b want 0", busy); end
      vectors++; if (load_cnt !== lb) begin miscompares++; $display("FAIL ferr_load got %0d want 0", load_cnt - lb); end
      vectors++; if (data_out !== 8'hFF) begin miscompares++; $display("FAIL ferr_data_kept got %h want ff", data_out); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b  = 8'h81;
      int         lb;
      send_bits(1'b0);
      for (int i = 0; i < 4; i++) send_bits(b[i]);
      rx = b[4];
      repeat (8) @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL mid_rst_data got %h want 00", data_out); end
      vectors++; if (load !== 1'b0) begin miscompares++; $display("FAIL mid_rst_load got %b want 0", load); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got %b want 0", busy); end
      @(negedge clk);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      lb = load_cnt;
      send_frame(8'h42, 1'b1);
      repeat (2) @(negedge clk);
      vectors++; if (data_out !== 8'h42) begin miscompares++; $display("FAIL mid_rst_next_data got %h want 42", data_out); end
      vectors++; if (load_cnt !== lb + 1) begin miscompares++; $display("FAIL mid_rst_next_load got %0d want 1", load_cnt - lb); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_good_byte();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_reset_mid_frame();
      vectors++; if (overlap_cnt !== 0) begin miscompares++; $display("FAIL strobe_overlap got %0d want 0", overlap_cnt); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
